// File: rtl/button_events_if.sv
// Event bus between the button event controller and its consumer: debounced
// press/release pulses in, one arbitrated valid/ready event stream out.
interface button_events_if #(
    parameter int BTNS = 4
) ();
    localparam int IW = $clog2(BTNS);

    logic [BTNS-1:0] btn_dn;
    logic [BTNS-1:0] btn_up;
    logic            ev_valid;
    logic            ev_ready;
    logic [IW-1:0]   ev_btn;
    logic [1:0]      ev_type;
    logic [BTNS-1:0] ovf;
    logic            ovf_clr;

    modport master (
        input  btn_dn,
        input  btn_up,
        input  ev_ready,
        input  ovf_clr,
        output ev_valid,
        output ev_btn,
        output ev_type,
        output ovf
    );

    modport slave (
        output btn_dn,
        output btn_up,
        output ev_ready,
        output ovf_clr,
        input  ev_valid,
        input  ev_btn,
        input  ev_type,
        input  ovf
    );
endinterface

// File: rtl/button_events.sv
// Auto-repeat button event controller: per-button FSM, one pending slot per
// button, round-robin arbitration onto a single registered valid/ready output.
module button_events #(
    parameter int BTNS          = 4,
    parameter int CNTW          = 24,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000
) (
    input logic               clk,
    input logic               rst_n,
    button_events_if.master   bus
);
    localparam int IW = $clog2(BTNS);
    localparam logic [CNTW-1:0] DELAY_LAST  = CNTW'(REPEAT_DELAY - 1);
    localparam logic [CNTW-1:0] PERIOD_LAST = CNTW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_t;

    typedef enum logic [1:0] {
        EV_PRESS   = 2'd0,
        EV_REPEAT  = 2'd1,
        EV_RELEASE = 2'd2
    } ev_t;

    state_t          state [BTNS];
    logic [CNTW-1:0] cnt   [BTNS];

    logic [BTNS-1:0] gen_v;
    ev_t             gen_t [BTNS];

    logic [BTNS-1:0] pend_v;
    ev_t             pend_t [BTNS];
    logic [BTNS-1:0] ovf_q;
    logic [BTNS-1:0] ovf_set;

    logic            ev_valid_q;
    logic [IW-1:0]   ev_btn_q;
    ev_t             ev_type_q;
    logic [IW-1:0]   ptr;

    logic            loadable;
    logic            grant_any;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   ptr_next;
    logic [BTNS-1:0] drain;
    int              j;

    // A release wins over everything, including a simultaneous press or terminal count.
    always_comb begin
        for (int i = 0; i < BTNS; i++) begin
            gen_v[i] = 1'b0;
            gen_t[i] = EV_PRESS;
            if (bus.btn_up[i]) begin
                if (state[i] != ST_IDLE) begin
                    gen_v[i] = 1'b1;
                    gen_t[i] = EV_RELEASE;
                end
            end else if (bus.btn_dn[i]) begin
                gen_v[i] = 1'b1;
                gen_t[i] = EV_PRESS;
            end else if (state[i] == ST_DELAY && cnt[i] == DELAY_LAST) begin
                gen_v[i] = 1'b1;
                gen_t[i] = EV_REPEAT;
            end else if (state[i] == ST_REPEAT && cnt[i] == PERIOD_LAST) begin
                gen_v[i] = 1'b1;
                gen_t[i] = EV_REPEAT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTNS; i++) begin
                state[i] <= ST_IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < BTNS; i++) begin
                if (bus.btn_up[i]) begin
                    state[i] <= ST_IDLE;
                    cnt[i]   <= '0;
                end else if (bus.btn_dn[i]) begin
                    state[i] <= ST_DELAY;
                    cnt[i]   <= '0;
                end else begin
                    case (state[i])
                        ST_DELAY: begin
                            if (cnt[i] == DELAY_LAST) begin
                                state[i] <= ST_REPEAT;
                                cnt[i]   <= '0;
                            end else begin
                                cnt[i] <= cnt[i] + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (cnt[i] == PERIOD_LAST) begin
                                cnt[i] <= '0;
                            end else begin
                                cnt[i] <= cnt[i] + 1'b1;
                            end
                        end
                        default: begin
                            state[i] <= ST_IDLE;
                            cnt[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Search starts at the round-robin pointer and wraps past the last button.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int k = 0; k < BTNS; k++) begin
            j = int'(ptr) + k;
            if (j >= BTNS) begin
                j = j - BTNS;
            end
            if (!grant_any && pend_v[j]) begin
                grant_any = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    always_comb begin
        loadable = !ev_valid_q || bus.ev_ready;
        drain    = '0;
        if (loadable && grant_any) begin
            drain[grant_idx] = 1'b1;
        end
        if (grant_idx == IW'(BTNS - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + 1'b1;
        end
    end

    // Losing a queued PRESS or RELEASE is an overflow; losing a REPEAT is not.
    always_comb begin
        for (int i = 0; i < BTNS; i++) begin
            ovf_set[i] = gen_v[i] && (gen_t[i] != EV_REPEAT) && pend_v[i] &&
                         !drain[i] && (pend_t[i] != EV_REPEAT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_v <= '0;
            ovf_q  <= '0;
            for (int i = 0; i < BTNS; i++) begin
                pend_t[i] <= EV_PRESS;
            end
        end else begin
            ovf_q <= (ovf_q & ~{BTNS{bus.ovf_clr}}) | ovf_set;
            for (int i = 0; i < BTNS; i++) begin
                if (gen_v[i]) begin
                    if (!pend_v[i] || drain[i]) begin
                        pend_v[i] <= 1'b1;
                        pend_t[i] <= gen_t[i];
                    end else if (gen_t[i] != EV_REPEAT) begin
                        pend_t[i] <= gen_t[i];
                    end
                end else if (drain[i]) begin
                    pend_v[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ev_valid_q <= 1'b0;
            ev_btn_q   <= '0;
            ev_type_q  <= EV_PRESS;
            ptr        <= '0;
        end else if (loadable) begin
            ev_valid_q <= grant_any;
            if (grant_any) begin
                ev_btn_q  <= grant_idx;
                ev_type_q <= pend_t[grant_idx];
                ptr       <= ptr_next;
            end
        end
    end

    assign bus.ev_valid = ev_valid_q;
    assign bus.ev_btn   = ev_btn_q;
    assign bus.ev_type  = ev_type_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: round-robin vector table plus hand-written
// auto-repeat, backpressure, overflow and mid-operation reset sequences.
module tb_button_events;
    localparam int BTNS = 4;
    localparam logic [1:0] T_PRESS   = 2'd0;
    localparam logic [1:0] T_REPEAT  = 2'd1;
    localparam logic [1:0] T_RELEASE = 2'd2;

    typedef struct {
        logic [3:0] dn;
        logic [3:0] up;
        logic       rdy;
        logic       clr;
        logic       exp_v;
        logic [1:0] exp_btn;
        logic [1:0] exp_type;
        logic [3:0] exp_ovf;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[$];

    button_events_if #(.BTNS(BTNS)) bus ();

    button_events #(
        .BTNS(BTNS),
        .CNTW(8),
        .REPEAT_DELAY(8),
        .REPEAT_PERIOD(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkField(input string name, input int got, input int want);
        n_checks++;
        if (got == want) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [1:0] eb,
                               input logic [1:0] et, input logic [3:0] eo);
        checkField({name, " ev_valid"}, int'(bus.ev_valid), int'(ev));
        if (ev) begin
            checkField({name, " ev_btn"}, int'(bus.ev_btn), int'(eb));
            checkField({name, " ev_type"}, int'(bus.ev_type), int'(et));
        end
        checkField({name, " ovf"}, int'(bus.ovf), int'(eo));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic [3:0] dn, input logic [3:0] up,
                                 input logic rdy, input logic clr);
        @(negedge clk);
        bus.btn_dn   = dn;
        bus.btn_up   = up;
        bus.ev_ready = rdy;
        bus.ovf_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic [3:0] dn, input logic [3:0] up, input logic ev,
                          input logic [1:0] eb, input logic [1:0] et);
        vec_t v;
        v.dn = dn; v.up = up; v.rdy = 1'b1; v.clr = 1'b0;
        v.exp_v = ev; v.exp_btn = eb; v.exp_type = et; v.exp_ovf = 4'b0000;
        vecs.push_back(v);
    endtask

    function automatic logic arValid(input int t);
        return (t == 1) || (t == 33) || (t >= 9 && t <= 29 && ((t - 9) % 4) == 0);
    endfunction

    function automatic logic [1:0] arType(input int t);
        if (t == 1) return T_PRESS;
        if (t == 33) return T_RELEASE;
        return T_REPEAT;
    endfunction

    initial begin
        bus.btn_dn   = '0;
        bus.btn_up   = '0;
        bus.ev_ready = 1'b0;
        bus.ovf_clr  = 1'b0;

        // Reset state
        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        checkOutput("reset", 1'b0, 2'd0, T_PRESS, 4'b0000);
        checkField("reset ev_btn", int'(bus.ev_btn), 0);
        checkField("reset ev_type", int'(bus.ev_type), 0);
        rst_n = 1'b1;

        // Round-robin from pointer 0, then from pointer 2
        addVec(4'b1111, 4'b0000, 1'b0, 2'd0, T_PRESS);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd0, T_PRESS);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd1, T_PRESS);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd2, T_PRESS);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd3, T_PRESS);
        addVec(4'b0000, 4'b0000, 1'b0, 2'd0, T_PRESS);
        addVec(4'b0000, 4'b1111, 1'b0, 2'd0, T_PRESS);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd0, T_RELEASE);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd1, T_RELEASE);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd2, T_RELEASE);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd3, T_RELEASE);
        addVec(4'b0000, 4'b0000, 1'b0, 2'd0, T_PRESS);
        addVec(4'b0010, 4'b0000, 1'b0, 2'd0, T_PRESS);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd1, T_PRESS);
        addVec(4'b0000, 4'b0010, 1'b0, 2'd0, T_PRESS);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd1, T_RELEASE);
        addVec(4'b0000, 4'b0000, 1'b0, 2'd0, T_PRESS);
        addVec(4'b1111, 4'b0000, 1'b0, 2'd0, T_PRESS);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd2, T_PRESS);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd3, T_PRESS);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd0, T_PRESS);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd1, T_PRESS);
        addVec(4'b0000, 4'b1111, 1'b0, 2'd0, T_PRESS);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd2, T_RELEASE);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd3, T_RELEASE);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd0, T_RELEASE);
        addVec(4'b0000, 4'b0000, 1'b1, 2'd1, T_RELEASE);
        addVec(4'b0000, 4'b0000, 1'b0, 2'd0, T_PRESS);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].dn, vecs[i].up, vecs[i].rdy, vecs[i].clr);
            checkOutput($sformatf("rr[%0d]", i), vecs[i].exp_v, vecs[i].exp_btn,
                        vecs[i].exp_type, vecs[i].exp_ovf);
        end

        // Auto-repeat on button 0; release lands on a terminal count
        for (int t = 0; t <= 40; t++) begin
            applyStimulus((t == 0) ? 4'b0001 : 4'b0000, (t == 32) ? 4'b0001 : 4'b0000,
                          1'b1, 1'b0);
            checkOutput($sformatf("repeat[%0d]", t), arValid(t), 2'd0, arType(t), 4'b0000);
        end

        // Backpressure: PRESS held stable, release during stall delivered afterwards
        for (int c = 0; c <= 22; c++) begin
            applyStimulus((c == 0) ? 4'b1000 : 4'b0000, (c == 3) ? 4'b1000 : 4'b0000,
                          (c >= 21), 1'b0);
            if (c == 0 || c == 22) begin
                checkOutput($sformatf("stall[%0d]", c), 1'b0, 2'd3, T_PRESS, 4'b0000);
            end else if (c == 21) begin
                checkOutput($sformatf("stall[%0d]", c), 1'b1, 2'd3, T_RELEASE, 4'b0000);
            end else begin
                checkOutput($sformatf("stall[%0d]", c), 1'b1, 2'd3, T_PRESS, 4'b0000);
            end
        end

        // Overflow on button 1, clear, then clear coincident with a new overflow
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
        checkOutput("ovf c0", 1'b0, 2'd1, T_PRESS, 4'b0000);
        applyStimulus(4'b0000, 4'b0010, 1'b0, 1'b0);
        checkOutput("ovf c1", 1'b1, 2'd1, T_PRESS, 4'b0000);
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
        checkOutput("ovf c2", 1'b1, 2'd1, T_PRESS, 4'b0010);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        checkOutput("ovf c3", 1'b1, 2'd1, T_PRESS, 4'b0010);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        checkOutput("ovf c4", 1'b0, 2'd1, T_PRESS, 4'b0010);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1);
        checkOutput("ovf clr", 1'b0, 2'd1, T_PRESS, 4'b0000);
        applyStimulus(4'b0000, 4'b0010, 1'b0, 1'b0);
        checkOutput("ovf c6", 1'b0, 2'd1, T_PRESS, 4'b0000);
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
        checkOutput("ovf c7", 1'b1, 2'd1, T_RELEASE, 4'b0000);
        applyStimulus(4'b0000, 4'b0010, 1'b0, 1'b1);
        checkOutput("ovf set+clr", 1'b1, 2'd1, T_RELEASE, 4'b0010);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        checkOutput("ovf c9", 1'b1, 2'd1, T_RELEASE, 4'b0010);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        checkOutput("ovf c10", 1'b0, 2'd1, T_PRESS, 4'b0010);

        // Reset while button 3 is repeating with an event on the output
        for (int c = 0; c <= 9; c++) begin
            applyStimulus((c == 0) ? 4'b1000 : 4'b0000, 4'b0000, 1'b1, 1'b0);
        end
        checkOutput("pre-reset", 1'b1, 2'd3, T_REPEAT, 4'b0010);
        rst_n = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        rst_n = 1'b1;
        checkOutput("mid-reset", 1'b0, 2'd0, T_PRESS, 4'b0000);
        for (int c = 0; c < 15; c++) begin
            applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
            checkOutput($sformatf("post-reset[%0d]", c), 1'b0, 2'd0, T_PRESS, 4'b0000);
        end
        applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b0);
        checkOutput("repress c0", 1'b0, 2'd3, T_PRESS, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        checkOutput("repress c1", 1'b1, 2'd3, T_PRESS, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
